// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - opcodes and FSM states shared by the logic op arbiter
// Purpose: opcode localparams OP_AND..OP_XNOR (OP_W bits) and result FSM states.
// Ports: none (package).
package logic_op_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant: first request at or after ptr, wrapping
// Purpose: combinational round-robin selection among N requesters.
// Ports: req (N) requests, ptr (ID_W) search start,
//        grant (N) one-hot grant, grant_idx (ID_W) index of grant, any (1) some request seen.
module rr_arbiter #(
   parameter  int N    = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any
);

   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_idx;

   // Walk N positions starting at ptr; wrap is a subtract so N need not be a power of two.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(N)) begin
            w_sum = w_sum - (ID_W+1)'(N);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!any && req[w_idx]) begin
            any          = 1'b1;
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin shared bitwise logic unit with one result register
// Purpose: N_REQ requesters share one WIDTH-bit AND/OR/NOR/NAND/XOR/XNOR unit.
// Ports: clk, rst_n (async active-low); req_valid/req_op/req_a/req_b per requester in,
//        req_ready per requester out; rsp_valid/rsp_id/rsp_data/rsp_err out, rsp_ready in.
// Option: LOGIC_ARB_GRANT_CNT_EN adds grant_cnt, a 16-bit wrapping accept counter per requester.
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [OP_W*N_REQ-1:0]   req_op,
   input  logic [WIDTH*N_REQ-1:0]  req_a,
   input  logic [WIDTH*N_REQ-1:0]  req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err
`ifdef LOGIC_ARB_GRANT_CNT_EN
   ,
   output logic [16*N_REQ-1:0]     grant_cnt
`endif
);

   state_t            r_state;
   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [WIDTH-1:0]  r_rsp_data;
   logic              r_rsp_err;
   logic [ID_W-1:0]   r_ptr;

   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_gidx;
   logic              w_any;
   logic              w_can_issue;
   logic              w_accept;
   logic [OP_W-1:0]   w_op;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [WIDTH-1:0]  w_res;
   logic              w_err;
   logic [ID_W-1:0]   w_ptr_next;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .any       (w_any)
   );

   // A slot is free when empty or when the held result drains this same cycle.
   assign w_can_issue = (r_state == ST_EMPTY) | rsp_ready;
   // rst_n gating keeps req_ready low during reset even though the FSM already reads EMPTY.
   assign req_ready   = w_grant & {N_REQ{w_can_issue & rst_n}};
   assign w_accept    = w_any & w_can_issue & rst_n;
   assign w_ptr_next  = (w_gidx == ID_W'(N_REQ-1)) ? '0 : w_gidx + 1'b1;

   always_comb begin
      w_op  = req_op[int'(w_gidx)*OP_W +: OP_W];
      w_a   = req_a[int'(w_gidx)*WIDTH +: WIDTH];
      w_b   = req_b[int'(w_gidx)*WIDTH +: WIDTH];
      w_err = 1'b0;
      case (w_op)
         OP_AND:  w_res = w_a & w_b;
         OP_OR:   w_res = w_a | w_b;
         OP_NOR:  w_res = ~(w_a | w_b);
         OP_NAND: w_res = ~(w_a & w_b);
         OP_XOR:  w_res = w_a ^ w_b;
         OP_XNOR: w_res = ~(w_a ^ w_b);
         default: begin
            w_res = '0;
            w_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_ptr       <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_state     <= ST_FULL;
                  r_rsp_valid <= 1'b1;
               end
            end
            ST_FULL: begin
               if (!w_accept && rsp_ready) begin
                  r_state     <= ST_EMPTY;
                  r_rsp_valid <= 1'b0;
               end
            end
         endcase
         if (w_accept) begin
            r_rsp_data <= w_res;
            r_rsp_id   <= w_gidx;
            r_rsp_err  <= w_err;
            r_ptr      <= w_ptr_next;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

`ifdef LOGIC_ARB_GRANT_CNT_EN
   logic [N_REQ-1:0][15:0] r_grant_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_accept && w_grant[i]) begin
               r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [3*N-1:0] req_op = '0;
   logic [W*N-1:0] req_a = '0;
   logic [W*N-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic           rsp_err;
`ifdef LOGIC_ARB_GRANT_CNT_EN
   logic [16*N-1:0] grant_cnt;
`endif

   logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
`ifdef LOGIC_ARB_GRANT_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state
   bit         m_valid;
   int         m_id;
   logic [7:0] m_data;
   bit         m_err;
   int         m_ptr;
   int         m_cnt [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // {err, data}
   function automatic logic [8:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         0: return {1'b0, a & b};
         1: return {1'b0, a | b};
         2: return {1'b0, ~(a | b)};
         3: return {1'b0, ~(a & b)};
         4: return {1'b0, a ^ b};
         5: return {1'b0, ~(a ^ b)};
         default: return {1'b1, 8'h00};
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_data = 0; m_err = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic set_req(input int i, input int op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3] = op[2:0];
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
   endtask

   // Called just after a falling edge with inputs driven; returns accepted requester or -1.
   task automatic cycle(output int acc);
      int g;
      bit can;
      logic [N-1:0] exp_rdy;
      logic [8:0] r;
      #1;
      g = pick(req_valid, m_ptr);
      can = !m_valid || rsp_ready;
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      acc = (g >= 0 && can) ? g : -1;
      @(posedge clk);
      if (acc >= 0) begin
         r = ref_op(int'(req_op[3*acc +: 3]), req_a[W*acc +: W], req_b[W*acc +: W]);
         m_valid = 1; m_id = acc; m_err = r[8]; m_data = r[7:0];
         m_ptr = (acc + 1) % N;
         m_cnt[acc] = (m_cnt[acc] + 1) & 16'hFFFF;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         check("rsp_id", 32'(rsp_id), 32'(m_id));
         check("rsp_data", 32'(rsp_data), 32'(m_data));
         check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
`ifdef LOGIC_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif
   endtask

   initial begin
      int acc;
      int nxt;
      logic [7:0] exp6 [6];
      exp6[0] = 8'h05; exp6[1] = 8'hAF; exp6[2] = 8'h50;
      exp6[3] = 8'hFA; exp6[4] = 8'hAA; exp6[5] = 8'h55;
      model_reset();

      // reset state, with requests pending
      req_valid = 4'hF;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;

      // fairness: all valid, result consumed every cycle
      for (int i = 0; i < N; i++) set_req(i, i, 8'h3C + 8'(i), 8'h5A);
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle(acc);
         check("fair_order", 32'(acc), 32'(k % N));
      end

      // single op on requester 1
      req_valid = 4'b0010;
      set_req(1, 4, 8'hF0, 8'h3C);
      cycle(acc);
      check("single_data", 32'(rsp_data), 32'h00CC);
      check("single_id", 32'(rsp_id), 1);
      check("single_err", 32'(rsp_err), 0);

      // backpressure while FULL
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      repeat (5) begin
         cycle(acc);
         check("bp_no_accept", 32'(acc), 32'hFFFFFFFF);
         check("bp_hold_data", 32'(rsp_data), 32'h00CC);
      end
      rsp_ready = 1'b1;
      cycle(acc);
      check("bp_drain_accept", 32'(acc), 2);

      // illegal opcode; pointer still advances
      req_valid = 4'b0001;
      set_req(0, 7, 8'hFF, 8'hFF);
      cycle(acc);
      check("ill_err", 32'(rsp_err), 1);
      check("ill_data", 32'(rsp_data), 0);
      req_valid = 4'b0011;
      set_req(1, 0, 8'hFF, 8'h0F);
      cycle(acc);
      check("ill_ptr_adv", 32'(acc), 1);

      // every opcode on requester 2
      req_valid = 4'b0100;
      for (int op = 0; op < 6; op++) begin
         set_req(2, op, 8'hA5, 8'h0F);
         cycle(acc);
         check("op_table", 32'(rsp_data), 32'(exp6[op]));
      end

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         req_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 7), 8'($urandom), 8'($urandom));
         rsp_ready = ($urandom_range(0, 9) < 7);
         cycle(acc);
      end

      // reset in the middle of a FULL cycle
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      cycle(acc);
      check("pre_rst_full", 32'(rsp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_req_ready", 32'(req_ready), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      cycle(acc);
      check("post_rst_grant", 32'(acc), 0);
      cycle(nxt);
      check("post_rst_next", 32'(nxt), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
